// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, fetch-stage state codes and
// program depth.
package cpu_pkg;

  localparam logic [3:0] OP_SETC  = 4'b0000;
  localparam logic [3:0] OP_INPUT = 4'b0001;
  localparam logic [3:0] OP_COPY  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_NEG   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_SHL   = 4'b1000;
  localparam logic [3:0] OP_GT    = 4'b1011;
  localparam logic [3:0] OP_JIF   = 4'b1100;
  localparam logic [3:0] OP_HALT  = 4'b1110;

  localparam int PROG_DEPTH = 128;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE   = 2'd0;
  localparam fetch_state_t ST_RUN    = 2'd1;
  localparam fetch_state_t ST_HALTED = 2'd2;
  localparam fetch_state_t ST_FAULT  = 2'd3;

endpackage

// File: rtl/fetch_unit.sv
// Program counter and instruction-fetch stage in front of instructionMemory.
// Handles start, stall, jump redirect, HALT detection and out-of-range faults,
// and counts retired fetches since the last start.
module fetch_unit #(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          PROG_DEPTH  = cpu_pkg::PROG_DEPTH,
  parameter logic [3:0]  HALT_OPCODE = cpu_pkg::OP_HALT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            programSelect,
  input  logic                  stall,
  input  logic                  jumpValid,
  input  logic [ADDR_WIDTH-1:0] jumpTarget,
  input  logic [15:0]           instruction,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [7:0]            programSelectOut,
  output logic [15:0]           instrReg,
  output logic                  instrValid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  running,
  output logic                  halted,
  output logic                  fault,
  output logic [15:0]           fetchCount
);

  import cpu_pkg::*;

  // Depth compared with one extra bit so PROG_DEPTH == 2**ADDR_WIDTH still works.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(PROG_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PC   = ADDR_WIDTH'(PROG_DEPTH - 1);

  fetch_state_t state;

  logic jump_ok;
  logic is_halt;

  // Redirect legality and HALT decode of the word currently on the bus.
  always_comb begin
    jump_ok = ({1'b0, jumpTarget} < DEPTH_EXT);
    is_halt = (instruction[15:12] == HALT_OPCODE);
  end

  // Status decode; address follows pc directly (combinational memory).
  always_comb begin
    address = pc;
    running = (state == ST_RUN);
    halted  = (state == ST_HALTED);
    fault   = (state == ST_FAULT);
  end

  // State machine, PC, instruction register and fetch counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      pc               <= '0;
      instrReg         <= '0;
      instrValid       <= 1'b0;
      programSelectOut <= '0;
      fetchCount       <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (jumpValid) begin
            // Redirect beats stall; the word on the bus this cycle is dropped.
            instrValid <= 1'b0;
            if (jump_ok) pc <= jumpTarget;
            else         state <= ST_FAULT;
          end else if (stall) begin
            instrValid <= 1'b0;
          end else begin
            instrReg   <= instruction;
            instrValid <= 1'b1;
            if (fetchCount != '1) fetchCount <= fetchCount + 16'd1;
            if (is_halt)              state <= ST_HALTED;
            else if (pc == LAST_PC)   state <= ST_FAULT;
            else                      pc    <= pc + 1'b1;
          end
        end
        default: begin
          // IDLE, HALTED and FAULT all wait for a start with a nonzero select.
          instrValid <= 1'b0;
          if (start && (programSelect != '0)) begin
            state            <= ST_RUN;
            pc               <= '0;
            programSelectOut <= programSelect;
            fetchCount       <= '0;
          end
        end
      endcase
    end
  end

endmodule
